// File: rtl/rf_pkg.sv
// Rename register file shared definitions: configuration widths, per-register
// entry layout, and packed-bus slicing helpers for the multi-port buses.
package rf_pkg;

    localparam int unsigned NUM_REGS = 256;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TAG_W    = 8;
    localparam int unsigned NUM_READ = 2;
    localparam int unsigned NUM_CPL  = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [TAG_W-1:0]  tag_t;

    // Tag and data are kept apart so commit can match the tag after completion.
    typedef struct packed {
        logic  place;
        data_t arch_data;
        logic  phys_valid;
        tag_t  phys_tag;
        data_t phys_data;
    } reg_entry_t;

    function automatic addr_t src_addr_at(input logic [NUM_READ*ADDR_W-1:0] vec,
                                          input int unsigned idx);
        return vec[idx*ADDR_W +: ADDR_W];
    endfunction

    function automatic addr_t cpl_addr_at(input logic [NUM_CPL*ADDR_W-1:0] vec,
                                          input int unsigned idx);
        return vec[idx*ADDR_W +: ADDR_W];
    endfunction

    function automatic tag_t cpl_tag_at(input logic [NUM_CPL*TAG_W-1:0] vec,
                                        input int unsigned idx);
        return vec[idx*TAG_W +: TAG_W];
    endfunction

    function automatic data_t cpl_data_at(input logic [NUM_CPL*DATA_W-1:0] vec,
                                          input int unsigned idx);
        return vec[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/rename_regfile_mp_if.sv
// Rename register file bus: rename, source reads, completions and commit.
// master = decode/rename side driving requests, slave = the register file.
interface rename_regfile_mp_if;
    import rf_pkg::*;

    logic                       flush;
    logic                       dest_en;
    addr_t                      dest_logic;
    tag_t                       dest_tag;
    logic [NUM_READ*ADDR_W-1:0] src_addr;
    logic [NUM_READ-1:0]        read_valid;
    logic [NUM_READ*DATA_W-1:0] read_data;
    logic [NUM_CPL-1:0]         cpl_en;
    logic [NUM_CPL*ADDR_W-1:0]  cpl_logic;
    logic [NUM_CPL*TAG_W-1:0]   cpl_tag;
    logic [NUM_CPL*DATA_W-1:0]  cpl_data;
    logic                       commit_en;
    addr_t                      commit_logic;
    tag_t                       commit_tag;
    data_t                      commit_data;

    modport master (
        output flush, dest_en, dest_logic, src_addr,
        output cpl_en, cpl_logic, cpl_tag, cpl_data,
        output commit_en, commit_logic, commit_tag, commit_data,
        input  dest_tag, read_valid, read_data
    );

    modport slave (
        input  flush, dest_en, dest_logic, src_addr,
        input  cpl_en, cpl_logic, cpl_tag, cpl_data,
        input  commit_en, commit_logic, commit_tag, commit_data,
        output dest_tag, read_valid, read_data
    );

endinterface

// File: rtl/rename_rf_read_port.sv
// One registered source-read port: completion bypass > physical > architectural.
// Ports: clock, reset_n, flush; entry = addressed register state; hit = per
// completion port "established on this address"; cpl_data = completion bus;
// read_valid/read_data = registered result (tag zero-extended when pending).
module rename_rf_read_port
    import rf_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  reg_entry_t                entry,
    input  logic [NUM_CPL-1:0]        hit,
    input  logic [NUM_CPL*DATA_W-1:0] cpl_data,
    output logic                      read_valid,
    output data_t                     read_data
);

    logic  valid_c;
    data_t data_c;

    // Priority mux; descending loop so the lowest completion port wins.
    always_comb begin
        valid_c = 1'b1;
        data_c  = entry.arch_data;
        if (entry.place) begin
            valid_c = entry.phys_valid;
            data_c  = entry.phys_valid ? entry.phys_data : DATA_W'(entry.phys_tag);
        end
        for (int k = NUM_CPL - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid_c = 1'b1;
                data_c  = cpl_data_at(cpl_data, k);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_valid <= 1'b0;
            read_data  <= '0;
        end else if (flush) begin
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            read_valid <= valid_c;
            read_data  <= data_c;
        end
    end

endmodule

// File: rtl/rename_regfile_mp.sv
// Multi-port rename register file: per logical register an architectural value
// plus an optional speculative mapping (pending tag or completed data).
// Ports: clock, reset_n (async, active-low); bus = rename/read/completion/commit
// interface (slave side).
module rename_regfile_mp
    import rf_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    rename_regfile_mp_if.slave   bus
);

    reg_entry_t         regs [NUM_REGS];
    tag_t               tag_cnt;
    logic [NUM_CPL-1:0] est_c;

    assign bus.dest_tag = tag_cnt;

    // A completion lands only if the register still waits on exactly that tag.
    always_comb begin
        est_c = '0;
        for (int unsigned k = 0; k < NUM_CPL; k++) begin
            est_c[k] = !bus.flush && bus.cpl_en[k]
                && regs[cpl_addr_at(bus.cpl_logic, k)].place
                && !regs[cpl_addr_at(bus.cpl_logic, k)].phys_valid
                && (regs[cpl_addr_at(bus.cpl_logic, k)].phys_tag == cpl_tag_at(bus.cpl_tag, k));
        end
    end

    // Update order encodes priority: commit, then completions (lowest port
    // last), then rename, so later non-blocking writes win.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            tag_cnt <= '0;
        end else begin
            if (bus.commit_en) begin
                regs[bus.commit_logic].arch_data <= bus.commit_data;
                if (regs[bus.commit_logic].place
                    && (regs[bus.commit_logic].phys_tag == bus.commit_tag)) begin
                    regs[bus.commit_logic].place <= 1'b0;
                end
            end
            if (bus.flush) begin
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    regs[r].place <= 1'b0;
                end
                tag_cnt <= '0;
            end else begin
                for (int k = NUM_CPL - 1; k >= 0; k--) begin
                    if (est_c[k]) begin
                        regs[cpl_addr_at(bus.cpl_logic, k)].phys_valid <= 1'b1;
                        regs[cpl_addr_at(bus.cpl_logic, k)].phys_data  <= cpl_data_at(bus.cpl_data, k);
                    end
                end
                if (bus.dest_en) begin
                    regs[bus.dest_logic].place      <= 1'b1;
                    regs[bus.dest_logic].phys_valid <= 1'b0;
                    regs[bus.dest_logic].phys_tag   <= tag_cnt;
                    tag_cnt                         <= tag_cnt + TAG_W'(1);
                end
            end
        end
    end

    logic [NUM_READ-1:0]        rv;
    logic [NUM_READ*DATA_W-1:0] rd;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        addr_t              addr;
        logic [NUM_CPL-1:0] hit_c;

        assign addr = src_addr_at(bus.src_addr, i);

        always_comb begin
            hit_c = '0;
            for (int unsigned k = 0; k < NUM_CPL; k++) begin
                hit_c[k] = est_c[k] && (cpl_addr_at(bus.cpl_logic, k) == addr);
            end
        end

        rename_rf_read_port u_port (
            .clock      (clock),
            .reset_n    (reset_n),
            .flush      (bus.flush),
            .entry      (regs[addr]),
            .hit        (hit_c),
            .cpl_data   (bus.cpl_data),
            .read_valid (rv[i]),
            .read_data  (rd[i*DATA_W +: DATA_W])
        );
    end

    assign bus.read_valid = rv;
    assign bus.read_data  = rd;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Self-checking bench for rename_regfile_mp: directed scenarios plus random
// traffic against a per-register reference model.
module tb_rename_regfile_mp;
    import rf_pkg::*;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    rename_regfile_mp_if bus ();

    rename_regfile_mp dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic  m_place [NUM_REGS];
    data_t m_arch  [NUM_REGS];
    logic  m_pv    [NUM_REGS];
    tag_t  m_tag   [NUM_REGS];
    data_t m_data  [NUM_REGS];
    tag_t  m_cnt;

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_place[r] = 1'b0;
            m_arch[r]  = '0;
            m_pv[r]    = 1'b0;
            m_tag[r]   = '0;
            m_data[r]  = '0;
        end
        m_cnt = '0;
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.dest_en      = 1'b0;
        bus.dest_logic   = '0;
        bus.src_addr     = '0;
        bus.cpl_en       = '0;
        bus.cpl_logic    = '0;
        bus.cpl_tag      = '0;
        bus.cpl_data     = '0;
        bus.commit_en    = 1'b0;
        bus.commit_logic = '0;
        bus.commit_tag   = '0;
        bus.commit_data  = '0;
    endtask

    task automatic set_src(input int i, input addr_t a);
        bus.src_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_cpl(input int k, input addr_t a, input tag_t t, input data_t d);
        bus.cpl_en[k]                    = 1'b1;
        bus.cpl_logic[k*ADDR_W +: ADDR_W] = a;
        bus.cpl_tag[k*TAG_W +: TAG_W]     = t;
        bus.cpl_data[k*DATA_W +: DATA_W]  = d;
    endtask

    task automatic set_commit(input addr_t a, input tag_t t, input data_t d);
        bus.commit_en    = 1'b1;
        bus.commit_logic = a;
        bus.commit_tag   = t;
        bus.commit_data  = d;
    endtask

    // One clock with the currently driven inputs; predicts reads from the model,
    // checks dest_tag before the edge and the read ports after it.
    task automatic step(input string name);
        logic  est [NUM_CPL];
        logic  ev  [NUM_READ];
        data_t ed  [NUM_READ];
        logic  fl;
        addr_t a;
        logic  found;

        fl = bus.flush;
        for (int k = 0; k < NUM_CPL; k++) begin
            a = cpl_addr_at(bus.cpl_logic, k);
            est[k] = !fl && bus.cpl_en[k] && m_place[a] && !m_pv[a]
                     && (m_tag[a] == cpl_tag_at(bus.cpl_tag, k));
        end
        for (int i = 0; i < NUM_READ; i++) begin
            a = src_addr_at(bus.src_addr, i);
            if (!m_place[a]) begin
                ev[i] = 1'b1;
                ed[i] = m_arch[a];
            end else if (m_pv[a]) begin
                ev[i] = 1'b1;
                ed[i] = m_data[a];
            end else begin
                ev[i] = 1'b0;
                ed[i] = DATA_W'(m_tag[a]);
            end
            found = 1'b0;
            for (int k = 0; k < NUM_CPL; k++) begin
                if (!found && est[k] && cpl_addr_at(bus.cpl_logic, k) == a) begin
                    found = 1'b1;
                    ev[i] = 1'b1;
                    ed[i] = cpl_data_at(bus.cpl_data, k);
                end
            end
            if (fl) ev[i] = 1'b0;
        end

        checks++;
        if (bus.dest_tag !== m_cnt) begin
            failures++;
            $display("FAIL %s dest_tag: got %0d expected %0d", name, bus.dest_tag, m_cnt);
        end

        @(posedge clock);
        #1;

        // Model update from the rules, using the pre-edge view computed above.
        if (bus.commit_en) begin
            m_arch[bus.commit_logic] = bus.commit_data;
            if (m_place[bus.commit_logic] && m_tag[bus.commit_logic] == bus.commit_tag)
                m_place[bus.commit_logic] = 1'b0;
        end
        if (fl) begin
            for (int r = 0; r < NUM_REGS; r++) m_place[r] = 1'b0;
            m_cnt = '0;
        end else begin
            for (int k = 0; k < NUM_CPL; k++) begin
                found = 1'b0;
                for (int j = 0; j < k; j++)
                    if (est[j] && cpl_addr_at(bus.cpl_logic, j) == cpl_addr_at(bus.cpl_logic, k))
                        found = 1'b1;
                if (est[k] && !found) begin
                    a = cpl_addr_at(bus.cpl_logic, k);
                    m_pv[a]   = 1'b1;
                    m_data[a] = cpl_data_at(bus.cpl_data, k);
                end
            end
            if (bus.dest_en) begin
                m_place[bus.dest_logic] = 1'b1;
                m_pv[bus.dest_logic]    = 1'b0;
                m_tag[bus.dest_logic]   = m_cnt;
                m_cnt = m_cnt + TAG_W'(1);
            end
        end

        for (int i = 0; i < NUM_READ; i++) begin
            checks++;
            if (bus.read_valid[i] !== ev[i]) begin
                failures++;
                $display("FAIL %s read%0d valid: got %0b expected %0b", name, i,
                         bus.read_valid[i], ev[i]);
            end
            if (!fl) begin
                checks++;
                if (bus.read_data[i*DATA_W +: DATA_W] !== ed[i]) begin
                    failures++;
                    $display("FAIL %s read%0d data: got %h expected %h", name, i,
                             bus.read_data[i*DATA_W +: DATA_W], ed[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        checks++;
        if (bus.read_valid !== '0 || bus.read_data !== '0 || bus.dest_tag !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b tag=%0d expected 0", bus.read_valid, bus.dest_tag);
        end
        set_src(0, 8'd5);
        set_src(1, 8'd5);
        step("reset_read");
        checks++;
        if (bus.read_valid !== 2'b11 || bus.read_data !== '0) begin
            failures++;
            $display("FAIL reset_r5: got valid=%b data=%h expected 11/0", bus.read_valid, bus.read_data);
        end
    endtask

    task automatic test_rename();
        idle();
        bus.dest_en = 1'b1; bus.dest_logic = 8'd3;
        checks++;
        if (bus.dest_tag !== 8'd0) begin
            failures++;
            $display("FAIL rename_first_tag: got %0d expected 0", bus.dest_tag);
        end
        step("rename_r3");
        idle();
        bus.dest_en = 1'b1; bus.dest_logic = 8'd3;
        set_src(0, 8'd3);
        checks++;
        if (bus.dest_tag !== 8'd1) begin
            failures++;
            $display("FAIL rename_second_tag: got %0d expected 1", bus.dest_tag);
        end
        step("rename_r3_again");
        checks++;
        if (bus.read_valid[0] !== 1'b0 || bus.read_data[DATA_W-1:0] !== 32'h0) begin
            failures++;
            $display("FAIL rename_read_tag: got v=%b d=%h expected 0/0",
                     bus.read_valid[0], bus.read_data[DATA_W-1:0]);
        end
    endtask

    task automatic test_cpl_bypass();
        idle();
        set_cpl(0, 8'd3, 8'd0, 32'hAA);
        set_src(0, 8'd3);
        step("stale_cpl");
        checks++;
        if (bus.read_valid[0] !== 1'b0 || bus.read_data[DATA_W-1:0] !== 32'h1) begin
            failures++;
            $display("FAIL stale_cpl: got v=%b d=%h expected 0/1",
                     bus.read_valid[0], bus.read_data[DATA_W-1:0]);
        end
        idle();
        set_cpl(0, 8'd3, 8'd1, 32'hBB);
        set_src(1, 8'd3);
        step("cpl_bypass");
        checks++;
        if (bus.read_valid[1] !== 1'b1 || bus.read_data[2*DATA_W-1:DATA_W] !== 32'hBB) begin
            failures++;
            $display("FAIL cpl_bypass: got v=%b d=%h expected 1/bb",
                     bus.read_valid[1], bus.read_data[2*DATA_W-1:DATA_W]);
        end
        idle();
        set_src(0, 8'd3);
        step("cpl_stored");
        checks++;
        if (bus.read_valid[0] !== 1'b1 || bus.read_data[DATA_W-1:0] !== 32'hBB) begin
            failures++;
            $display("FAIL cpl_stored: got v=%b d=%h expected 1/bb",
                     bus.read_valid[0], bus.read_data[DATA_W-1:0]);
        end
    endtask

    task automatic test_commit();
        idle(); set_commit(8'd3, 8'd1, 32'hBB); set_src(0, 8'd3); step("commit_r3");
        idle(); set_src(0, 8'd3); step("commit_r3_read");
        idle(); bus.dest_en = 1'b1; bus.dest_logic = 8'd9; step("rename_r9");
        idle(); set_commit(8'd9, 8'd2, 32'h77); step("commit_r9");
        idle(); set_src(0, 8'd9); step("commit_r9_read");
        checks++;
        if (bus.read_valid[0] !== 1'b1 || bus.read_data[DATA_W-1:0] !== 32'h77) begin
            failures++;
            $display("FAIL commit_release: got v=%b d=%h expected 1/77",
                     bus.read_valid[0], bus.read_data[DATA_W-1:0]);
        end
        idle(); bus.dest_en = 1'b1; bus.dest_logic = 8'd4; step("rename_r4");
        idle(); set_commit(8'd4, 8'd2, 32'h11); set_src(0, 8'd4); step("commit_old_tag");
        idle(); set_src(0, 8'd4); step("commit_old_read");
        checks++;
        if (bus.read_valid[0] !== 1'b0 || bus.read_data[DATA_W-1:0] !== 32'h3) begin
            failures++;
            $display("FAIL commit_old_tag: got v=%b d=%h expected 0/3",
                     bus.read_valid[0], bus.read_data[DATA_W-1:0]);
        end
    endtask

    task automatic test_rename_wins();
        idle(); bus.dest_en = 1'b1; bus.dest_logic = 8'd7; step("rename_r7");
        idle(); bus.dest_en = 1'b1; bus.dest_logic = 8'd7;
        set_cpl(1, 8'd7, 8'd4, 32'hCC); step("rename_vs_cpl");
        idle(); set_src(1, 8'd7); step("rename_wins_read");
        checks++;
        if (bus.read_valid[1] !== 1'b0 || bus.read_data[2*DATA_W-1:DATA_W] !== 32'h5) begin
            failures++;
            $display("FAIL rename_wins: got v=%b d=%h expected 0/5",
                     bus.read_valid[1], bus.read_data[2*DATA_W-1:DATA_W]);
        end
    endtask

    task automatic test_flush();
        idle(); bus.dest_en = 1'b1; bus.dest_logic = 8'd2; step("rename_r2");
        idle();
        bus.flush = 1'b1;
        bus.dest_en = 1'b1; bus.dest_logic = 8'd2;
        set_cpl(0, 8'd2, 8'd6, 32'hDD);
        set_commit(8'd2, 8'd9, 32'h55);
        set_src(0, 8'd2);
        step("flush");
        checks++;
        if (bus.read_valid !== 2'b00 || bus.dest_tag !== 8'd0) begin
            failures++;
            $display("FAIL flush_outputs: got v=%b tag=%0d expected 00/0", bus.read_valid, bus.dest_tag);
        end
        idle(); set_src(0, 8'd2); step("flush_read");
        checks++;
        if (bus.read_valid[0] !== 1'b1 || bus.read_data[DATA_W-1:0] !== 32'h55) begin
            failures++;
            $display("FAIL flush_arch: got v=%b d=%h expected 1/55",
                     bus.read_valid[0], bus.read_data[DATA_W-1:0]);
        end
    endtask

    task automatic test_random();
        addr_t a;
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.flush      = ($urandom_range(31) == 0);
            bus.dest_en    = 1'($urandom_range(1));
            bus.dest_logic = addr_t'($urandom_range(7));
            for (int i = 0; i < NUM_READ; i++) set_src(i, addr_t'($urandom_range(7)));
            for (int k = 0; k < NUM_CPL; k++) begin
                if ($urandom_range(1) == 1) begin
                    a = addr_t'($urandom_range(7));
                    set_cpl(k, a, ($urandom_range(3) != 0) ? m_tag[a] : tag_t'($urandom),
                            data_t'($urandom));
                end
            end
            if ($urandom_range(2) == 0) begin
                a = addr_t'($urandom_range(7));
                set_commit(a, ($urandom_range(1) == 1) ? m_tag[a] : tag_t'($urandom),
                           data_t'($urandom));
            end
            step("random");
        end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 4; n++) begin
            idle();
            bus.dest_en = 1'b1; bus.dest_logic = addr_t'(n);
            set_src(0, addr_t'(n)); set_src(1, 8'd0);
            step("pre_reset_burst");
        end
        bus.dest_en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.read_valid !== '0 || bus.read_data !== '0 || bus.dest_tag !== '0) begin
            failures++;
            $display("FAIL async_reset: got v=%b d=%h tag=%0d expected 0",
                     bus.read_valid, bus.read_data, bus.dest_tag);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        idle(); set_src(0, 8'd1); set_src(1, 8'd3); step("post_reset_read");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        idle();
        test_reset();
        test_rename();
        test_cpl_bypass();
        test_commit();
        test_rename_wins();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
